// File: rtl/frame_buf_reader_if.sv
// rtl/frame_buf_reader_if.sv - frame buffer read port and display output bundle
interface frame_buf_reader_if;
    logic [23:0] data_in;
    logic        rd_en_n;
    logic [23:0] pix_data;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic        frame_start;
    logic        busy;

    modport master (
        input  data_in,
        output rd_en_n, pix_data, de, hsync, vsync, frame_start, busy
    );

    modport slave (
        output data_in,
        input  rd_en_n, pix_data, de, hsync, vsync, frame_start, busy
    );
endinterface

// File: rtl/frame_buf_reader.sv
// rtl/frame_buf_reader.sv - raster scan-out controller for the frame buffer read side
module frame_buf_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic               rd_clk,
    input  logic               reset,
    input  logic               run,
    frame_buf_reader_if.master bus
);
    localparam logic [11:0] H_LAST = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] V_LAST = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t      state, state_nxt;
    logic [11:0] h_cnt, v_cnt, h_nxt, v_nxt;
    logic        at_last;
    logic        pos_active, pos_hs, pos_vs, pos_first;

    logic        s1_valid, s1_de, s1_hs, s1_vs, s1_fs;
    logic        s2_de, s2_hs, s2_vs, s2_fs;

    always_comb begin
        state_nxt  = state;
        h_nxt      = h_cnt;
        v_nxt      = v_cnt;
        at_last    = (h_cnt == H_LAST) && (v_cnt == V_LAST);
        pos_active = (state == SCAN) && (h_cnt < H_ACT) && (v_cnt < V_ACT);
        pos_hs     = (state == SCAN) && (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        pos_vs     = (state == SCAN) && (v_cnt >= VS_BEG) && (v_cnt < VS_END);
        pos_first  = (state == SCAN) && (h_cnt == 12'd0) && (v_cnt == 12'd0);

        case (state)
            IDLE: begin
                h_nxt = 12'd0;
                v_nxt = 12'd0;
                if (run) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (h_cnt == H_LAST) begin
                    h_nxt = 12'd0;
                    v_nxt = (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
                end else begin
                    h_nxt = h_cnt + 12'd1;
                end
                // run is only honoured at the frame boundary so the buffer's read pointer stays aligned
                if (at_last && !run) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (reset) begin
            state <= IDLE;
            h_cnt <= 12'd0;
            v_cnt <= 12'd0;
        end else begin
            state <= state_nxt;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    // Stage 1 issues the read, stage 2 waits out the buffer latency, stage 3 registers the pixel.
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            s1_valid        <= 1'b0;
            s1_de           <= 1'b0;
            s1_hs           <= 1'b0;
            s1_vs           <= 1'b0;
            s1_fs           <= 1'b0;
            s2_de           <= 1'b0;
            s2_hs           <= 1'b0;
            s2_vs           <= 1'b0;
            s2_fs           <= 1'b0;
            bus.rd_en_n     <= 1'b1;
            bus.pix_data    <= 24'd0;
            bus.de          <= 1'b0;
            bus.hsync       <= ~HS_POL;
            bus.vsync       <= ~VS_POL;
            bus.frame_start <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            s1_valid        <= (state == SCAN);
            s1_de           <= pos_active;
            s1_hs           <= pos_hs;
            s1_vs           <= pos_vs;
            s1_fs           <= pos_first;
            bus.rd_en_n     <= ~pos_active;
            s2_de           <= s1_de;
            s2_hs           <= s1_hs;
            s2_vs           <= s1_vs;
            s2_fs           <= s1_fs;
            bus.pix_data    <= s2_de ? bus.data_in : 24'd0;
            bus.de          <= s2_de;
            bus.hsync       <= s2_hs ? HS_POL : ~HS_POL;
            bus.vsync       <= s2_vs ? VS_POL : ~VS_POL;
            bus.frame_start <= s2_fs;
            // Drops once the final position has left stage 2, i.e. 3 cycles after its counter cycle
            bus.busy        <= (state_nxt == SCAN) || (state == SCAN) || s1_valid;
        end
    end
endmodule

// File: tb/tb_frame_buf_reader.sv
// tb/tb_frame_buf_reader.sv - self-checking bench for frame_buf_reader on an 8x6 raster
module tb_frame_buf_reader;
    logic clk = 1'b0;
    logic reset;
    logic run;

    always #5 clk = ~clk;

    frame_buf_reader_if bus ();

    frame_buf_reader #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .rd_clk(clk),
        .reset (reset),
        .run   (run),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Frame buffer model: 12 words holding 1..12, one-cycle read latency, pointer advances per read.
    bit   fixed_idle = 1'b1;
    int   bptr = 0;
    logic rd_prev = 1'b1;
    always @(negedge clk) begin
        if (rd_prev === 1'b0) begin
            bus.data_in = 24'(bptr + 1);
            bptr = (bptr + 1) % 12;
        end else begin
            bus.data_in = fixed_idle ? 24'hABCDEF : 24'($urandom);
        end
        rd_prev = bus.rd_en_n;
    end

    // Reference: raster position per cycle (index 0..47 in an 8x6 frame), delayed 3 cycles to the outputs.
    typedef struct {
        bit          scan;
        int          pos;
        logic [23:0] val;
    } ent_t;

    ent_t hist [4];
    bit   m_scan = 1'b0;
    int   m_pos = 0;
    int   exp_ptr = 0;
    int   cyc = 0;
    int   rd_cnt = 0;
    int   fs_cnt = 0;
    int   fs_last = -1;
    int   fs_gap = 0;
    int   fs_rd_snap = 0;
    int   frame_rd_base = 0;
    int   last47_cyc = 0;
    int   busy_fall_cyc = -1;
    logic prev_busy = 1'b0;
    bit   fs_seen = 1'b0;

    function automatic bit act(input int p);
        return ((p % 8) < 4) && ((p / 8) < 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    task automatic tick();
        bit   r;
        bit   rn;
        ent_t e;
        bit   a3;
        r  = reset;
        rn = run;
        @(posedge clk);
        cyc++;
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        if (r) begin
            for (int i = 0; i < 4; i++) hist[i] = '{1'b0, 0, 24'h0};
            m_scan = 1'b0;
            m_pos  = 0;
        end else begin
            if (m_scan) begin
                if (m_pos == 47 && !rn) begin
                    m_scan = 1'b0;
                    m_pos  = 0;
                end else begin
                    m_pos = (m_pos + 1) % 48;
                end
            end else if (rn) begin
                m_scan = 1'b1;
                m_pos  = 0;
            end
            hist[0] = '{m_scan, m_pos, 24'h0};
            if (hist[1].scan && act(hist[1].pos)) begin
                hist[1].val = 24'(exp_ptr + 1);
                exp_ptr = (exp_ptr + 1) % 12;
            end
        end
        @(negedge clk);
        e  = hist[3];
        a3 = e.scan && act(e.pos);
        chk("rd_en_n", 32'(bus.rd_en_n), 32'(!(hist[1].scan && act(hist[1].pos))));
        chk("de", 32'(bus.de), 32'(a3));
        chk("pix_data", {8'h0, bus.pix_data}, a3 ? {8'h0, e.val} : 32'h0);
        chk("hsync", 32'(bus.hsync), 32'(!(e.scan && (e.pos % 8) >= 5 && (e.pos % 8) <= 6)));
        chk("vsync", 32'(bus.vsync), 32'(!(e.scan && (e.pos / 8) == 4)));
        chk("frame_start", 32'(bus.frame_start), 32'(e.scan && e.pos == 0));
        chk("busy", 32'(bus.busy), 32'(hist[0].scan || hist[1].scan || hist[2].scan));

        if (bus.rd_en_n === 1'b0) rd_cnt++;
        if (hist[0].scan && hist[0].pos == 0) frame_rd_base = rd_cnt;
        if (hist[0].scan && hist[0].pos == 47) last47_cyc = cyc;
        if (prev_busy === 1'b1 && bus.busy === 1'b0) busy_fall_cyc = cyc;
        prev_busy = bus.busy;
        fs_seen = (bus.frame_start === 1'b1);
        if (fs_seen) begin
            if (fs_last >= 0) fs_gap = cyc - fs_last;
            fs_last    = cyc;
            fs_rd_snap = rd_cnt;
            fs_cnt++;
        end
    endtask

    task automatic wait_pos(input int p);
        int n;
        n = 0;
        while (!(m_scan && m_pos == p) && n < 200) begin
            tick();
            n++;
        end
        chk("wait_pos_timeout", 32'(n < 200), 32'd1);
    endtask

    initial begin
        int fs_before;
        int rd_before;
        int snap;
        int n;
        for (int i = 0; i < 4; i++) hist[i] = '{1'b0, 0, 24'h0};

        // Reset held with run high and constant read data
        reset = 1'b1;
        run   = 1'b1;
        fixed_idle = 1'b1;
        repeat (5) tick();

        // Two full frames of scan-out, data and syncs checked every cycle
        reset = 1'b0;
        fixed_idle = 1'b0;
        repeat (99) tick();
        chk("frames_after_release", 32'(fs_cnt), 32'd2);
        chk("fs_gap_first", 32'(fs_gap), 32'd48);

        // Drop run at the 10th active pixel: frame completes, nothing restarts
        wait_pos(17);
        fs_before = fs_cnt;
        run = 1'b0;
        repeat (60) tick();
        chk("drop_reads", 32'(rd_cnt - frame_rd_base), 32'd12);
        chk("drop_no_restart", 32'(fs_cnt), 32'(fs_before));
        chk("busy_fall_latency", 32'(busy_fall_cyc - last47_cyc), 32'd3);
        rd_before = rd_cnt;
        repeat ($urandom_range(1, 6)) tick();
        chk("idle_no_reads", 32'(rd_cnt), 32'(rd_before));

        // One-cycle reset at the 6th active pixel, then a fresh frame
        run = 1'b1;
        wait_pos(9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!fs_seen && n < 10);
        chk("restart_fs_latency", 32'(n), 32'd4);

        // Continuous run over three frames
        snap = fs_rd_snap;
        fs_before = fs_cnt;
        repeat (144) tick();
        chk("reads_3_frames", 32'(rd_cnt - snap), 32'd36);
        chk("fs_3_frames", 32'(fs_cnt - fs_before), 32'd3);
        chk("fs_gap_cont", 32'(fs_gap), 32'd48);

        run = 1'b0;
        repeat (60) tick();
        chk("final_busy", 32'(bus.busy), 32'd0);
        chk("final_rd_en_n", 32'(bus.rd_en_n), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/frame_buf_reader.md
# frame_buf_reader

Read-side scan-out controller for the dual-clock frame buffer. Runs in the read (display) clock domain, generates raster timing, and drives the buffer's active-low read enable so its one-cycle-latency 24-bit read data lands aligned with display enable and syncs. Output feeds the display/LVDS serializer path directly.

## Interface

**Parameters**
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync asserted level (0 = active-low)
- VS_POL, 0, vsync asserted level

**Ports**
- rd_clk, in, 1, display/read clock; sole clock
- reset, in, 1, synchronous, active-high
- run, in, 1, level; 1 = scan frames, 0 = stop at the next frame boundary
- data_in, in, 24, read data from frame buffer (RGB 8:8:8)
- rd_en_n, out, 1, active-low read enable to frame buffer
- pix_data, out, 24, pixel to display; 0 outside active region
- de, out, 1, display enable
- hsync, out, 1, horizontal sync (polarity HS_POL)
- vsync, out, 1, vertical sync (polarity VS_POL)
- frame_start, out, 1, one-cycle pulse with the first output pixel of each frame
- busy, out, 1, 1 while a frame is in progress

## Operation

- Counters h_cnt (0..H_TOTAL-1), v_cnt (0..V_TOTAL-1), 12 bits each; H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Each total is < 4096.
- Line order: active, front porch, sync, back porch. Frame order: the same, in lines.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- hsync is asserted when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. vsync uses the same rule on v_cnt and is asserted for whole lines.
- h_cnt wraps to 0 at H_TOTAL-1. v_cnt increments only on an h wrap and wraps to 0 at V_TOTAL-1.
- States:
  - IDLE: counters at 0, busy=0, rd_en_n=1, outputs at idle levels. When run=1, go to SCAN, with (0,0) as the first position the next cycle.
  - SCAN: counters advance every cycle. At the last position (H_TOTAL-1, V_TOTAL-1):
    - run=1: continue with the next frame seamlessly.
    - run=0: return to IDLE.
  - Deasserting run mid-frame never truncates a frame. The frame buffer's internal read pointer depends on exactly H_ACTIVE*V_ACTIVE reads per frame.
- Exactly H_ACTIVE*V_ACTIVE rd_en_n-low cycles occur per frame.
- Reset mid-frame: all state is forced to the reset values on the next edge and the block enters IDLE. The partial frame is abandoned.
- Reset values: rd_en_n=1, de=0, pix_data=0, hsync=~HS_POL, vsync=~VS_POL, frame_start=0, busy=0, counters 0.

## Timing

- Position P is held in the counters during cycle t.
- Cycle t+1: rd_en_n is low (registered) if P is active.
- Cycle t+2: the frame buffer drives data_in for P (fixed one-cycle read latency).
- Cycle t+3: pix_data (registered from data_in), de, hsync, vsync and frame_start for P are valid.
- Total latency is 3 cycles, counter to outputs. de/hsync/vsync pass through a 3-stage pipeline so all outputs stay mutually aligned.
- frame_start is high in the same cycle as the de/pix_data of P=(0,0).
- busy rises the cycle after IDLE→SCAN. It falls after the last position of the final frame has cleared the pipeline (3 cycles after that position's counter cycle).
- When de=0, pix_data=0 regardless of data_in.

## Test plan

Use a small raster: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1 (H_TOTAL=8); V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=6).

1. Reset held 5 cycles, run=1, data_in=24'hABCDEF → rd_en_n=1, de=0, pix_data=0, hsync=vsync=1, busy=0 throughout reset.
2. Release reset, run=1, data_in tracks a model frame buffer (values 24'h1..24'hC) → per frame:
   - 12 rd_en_n-low cycles, in 3 runs of 4;
   - de high 4 cycles per line, pix_data 1..C in order, 3 cycles after each counter position;
   - frame_start once per 48 cycles.
3. Sync check, same run → hsync low exactly for h positions 5–6 of every line, with 3-cycle output latency; vsync low for all 8 clocks of line 4 only.
4. Drop run at the 10th active pixel → the frame completes all 12 reads and 48 positions, no second frame starts, busy falls 3 cycles after position (7,5), rd_en_n stays 1.
5. Assert reset for 1 cycle at the 6th active pixel → the next edge shows reset values. With run=1 after release, a fresh frame starts at (0,0) with frame_start 4 cycles after reset release (IDLE→SCAN cycle plus 3-cycle latency).
6. Continuous run for 3 frames → frame_start pulses spaced exactly 48 cycles, 36 total reads, no gap cycles at frame wrap.
